// File: rtl/program_fetch.sv
// Purpose: program counter plus ROM fetch unit that splits each fetched byte into instr/oprnd nibbles.
// Latency: the byte is valid one cycle after FETCH is entered; sustained rate is one byte every two cycles.
// Backpressure: fetch_valid holds the byte and rom_addr until fetch_ready; load overrides everything but reset.
//
// Ports:
//   clk, reset          system clock, synchronous active-high reset
//   enable              permits new fetches
//   load, load_addr     jump request and target (highest priority after reset)
//   rom_addr            registered PC, drives the ROM address
//   rom_data            ROM read data, combinational from rom_addr
//   instr, oprnd        upper / lower half of the fetched word
//   fetch_valid         instr/oprnd hold a fetched word awaiting handshake
//   fetch_ready         consumer accepts the word this cycle
//   pc_wrap             one-cycle pulse after the PC rolls over from all-ones to zero
module program_fetch #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic                load,
    input  logic [ADDR_W-1:0]   load_addr,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [DATA_W-1:0]   rom_data,
    output logic [DATA_W/2-1:0] instr,
    output logic [DATA_W/2-1:0] oprnd,
    output logic                fetch_valid,
    input  logic                fetch_ready,
    output logic                pc_wrap
);

    localparam int NIB_W = DATA_W / 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t state, state_nxt;
    logic   handshake;
    logic   do_capture;
    logic   do_inc;

    assign handshake = fetch_valid & fetch_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state plus the datapath strobes. A load short-circuits the state
    // decode so it wins over a simultaneous handshake or capture.
    always_comb begin
        state_nxt  = state;
        do_capture = 1'b0;
        do_inc     = 1'b0;
        if (load) begin
            state_nxt = enable ? ST_FETCH : ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (enable) begin
                        state_nxt = ST_FETCH;
                    end
                end
                ST_FETCH: begin
                    do_capture = 1'b1;
                    state_nxt  = ST_HOLD;
                end
                ST_HOLD: begin
                    if (handshake) begin
                        do_inc    = 1'b1;
                        state_nxt = enable ? ST_FETCH : ST_IDLE;
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                end
            endcase
        end
    end

    // rom_addr only moves on load or increment, so the ROM output is stable
    // for the whole FETCH cycle and for as long as the byte is held.
    always_ff @(posedge clk) begin
        if (reset) begin
            rom_addr    <= '0;
            instr       <= '0;
            oprnd       <= '0;
            fetch_valid <= 1'b0;
            pc_wrap     <= 1'b0;
        end else begin
            pc_wrap <= 1'b0;
            if (load) begin
                rom_addr    <= load_addr;
                fetch_valid <= 1'b0;
            end else if (do_capture) begin
                instr       <= rom_data[DATA_W-1:NIB_W];
                oprnd       <= rom_data[NIB_W-1:0];
                fetch_valid <= 1'b1;
            end else if (do_inc) begin
                rom_addr    <= rom_addr + ADDR_W'(1);
                pc_wrap     <= &rom_addr;
                fetch_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_program_fetch.sv
// Purpose: randomized and directed bench for program_fetch against a flag-based behavioural model.
// Latency: model state is advanced at each rising edge and compared 1 time unit later.
// Backpressure: fetch_ready is randomized, including long stalls and jumps during a held byte.
module tb_program_fetch;

    logic        clk;
    logic        reset;
    logic        enable;
    logic        load;
    logic [11:0] load_addr;
    logic [11:0] rom_addr;
    logic [7:0]  rom_data;
    logic [3:0]  instr;
    logic [3:0]  oprnd;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        pc_wrap;

    logic [7:0]  rom [0:4095];

    int n_checks = 0;
    int n_fail   = 0;

    program_fetch #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .load        (load),
        .load_addr   (load_addr),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .oprnd       (oprnd),
        .fetch_valid (fetch_valid),
        .fetch_ready (fetch_ready),
        .pc_wrap     (pc_wrap)
    );

    assign rom_data = rom[rom_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the PC, whether a fetch request is outstanding,
    // and the byte currently offered to the consumer.
    logic [11:0] m_pc;
    logic        m_pending;
    logic        m_valid;
    logic [3:0]  m_instr;
    logic [3:0]  m_oprnd;
    logic        m_wrap;
    logic        armed = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            m_pc = 12'h000; m_pending = 1'b0; m_valid = 1'b0;
            m_instr = 4'h0; m_oprnd = 4'h0; m_wrap = 1'b0;
            armed = 1'b1;
        end else if (load) begin
            m_pc = load_addr; m_valid = 1'b0; m_wrap = 1'b0;
            m_pending = enable;
        end else begin
            m_wrap = 1'b0;
            if (m_valid) begin
                if (fetch_ready) begin
                    m_wrap    = (m_pc == 12'hFFF);
                    m_pc      = m_pc + 12'd1;
                    m_valid   = 1'b0;
                    m_pending = enable;
                end
            end else if (m_pending) begin
                m_instr   = rom[m_pc] >> 4;
                m_oprnd   = rom[m_pc] & 8'h0F;
                m_valid   = 1'b1;
                m_pending = 1'b0;
            end else if (enable) begin
                m_pending = 1'b1;
            end
        end
        #1;
        if (armed) begin
            chk("model_rom_addr", rom_addr, m_pc);
            chk("model_fetch_valid", fetch_valid, m_valid);
            chk("model_pc_wrap", pc_wrap, m_wrap);
            chk("model_instr", instr, m_instr);
            chk("model_oprnd", oprnd, m_oprnd);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) rom[i] = 8'($urandom);
        rom[12'h000] = 8'hA5;
        rom[12'h001] = 8'h3C;
        rom[12'hFFF] = 8'h7E;

        reset = 1'b1; enable = 1'b0; load = 1'b0; load_addr = 12'h000; fetch_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        chk("rst_rom_addr", rom_addr, 32'h000);
        chk("rst_valid", fetch_valid, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_oprnd", oprnd, 32'h0);
        chk("rst_wrap", pc_wrap, 32'h0);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("idle_no_valid", fetch_valid, 32'h0);
        end

        // Straight-line fetch of two bytes.
        enable = 1'b1; fetch_ready = 1'b1;
        tick();
        chk("fetch_not_yet_valid", fetch_valid, 32'h0);
        tick();
        chk("b0_valid", fetch_valid, 32'h1);
        chk("b0_instr", instr, 32'hA);
        chk("b0_oprnd", oprnd, 32'h5);
        tick();
        chk("b0_hs_addr", rom_addr, 32'h001);
        chk("b0_hs_valid", fetch_valid, 32'h0);
        tick();
        chk("b1_valid", fetch_valid, 32'h1);
        chk("b1_instr", instr, 32'h3);
        chk("b1_oprnd", oprnd, 32'hC);

        // Backpressure while holding the byte at 0x000.
        reset = 1'b1; tick(); reset = 1'b0;
        fetch_ready = 1'b0;
        tick(); tick();
        for (int i = 0; i < 3; i++) begin
            chk("stall_valid", fetch_valid, 32'h1);
            chk("stall_instr", instr, 32'hA);
            chk("stall_oprnd", oprnd, 32'h5);
            chk("stall_addr", rom_addr, 32'h000);
            tick();
        end
        fetch_ready = 1'b1;
        tick();
        chk("stall_release_addr", rom_addr, 32'h001);
        chk("stall_release_valid", fetch_valid, 32'h0);

        // Load on the same edge as a handshake at 0x000.
        reset = 1'b1; tick(); reset = 1'b0;
        fetch_ready = 1'b0;
        tick(); tick();
        fetch_ready = 1'b1; load = 1'b1; load_addr = 12'h001;
        tick();
        load = 1'b0;
        chk("load_hs_valid", fetch_valid, 32'h0);
        chk("load_hs_addr", rom_addr, 32'h001);
        tick();
        chk("load_hs_instr", instr, 32'h3);
        chk("load_hs_oprnd", oprnd, 32'hC);
        chk("load_hs_valid2", fetch_valid, 32'h1);

        // Reset while holding with ready asserted.
        reset = 1'b1;
        tick();
        reset = 1'b0; enable = 1'b0;
        chk("hold_rst_valid", fetch_valid, 32'h0);
        chk("hold_rst_addr", rom_addr, 32'h000);
        chk("hold_rst_instr", instr, 32'h0);
        chk("hold_rst_oprnd", oprnd, 32'h0);
        tick();
        chk("hold_rst_idle", fetch_valid, 32'h0);

        // Jump to the last address and wrap.
        enable = 1'b1; fetch_ready = 1'b1; load = 1'b1; load_addr = 12'hFFF;
        tick();
        load = 1'b0;
        chk("top_addr", rom_addr, 32'hFFF);
        tick();
        chk("top_instr", instr, 32'h7);
        chk("top_oprnd", oprnd, 32'hE);
        chk("top_wrap_low", pc_wrap, 32'h0);
        tick();
        chk("wrap_addr", rom_addr, 32'h000);
        chk("wrap_pulse", pc_wrap, 32'h1);
        tick();
        chk("wrap_one_cycle", pc_wrap, 32'h0);
        load = 1'b1; load_addr = 12'h000;
        tick();
        load = 1'b0;
        chk("load_zero_no_wrap", pc_wrap, 32'h0);

        // Randomized traffic; jump targets biased toward the top of memory.
        for (int i = 0; i < 3000; i++) begin
            reset       = ($urandom_range(0, 99) == 0);
            load        = ($urandom_range(0, 15) == 0);
            enable      = ($urandom_range(0, 3) != 0);
            fetch_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 1) == 0)
                load_addr = 12'hFFF - 12'($urandom_range(0, 3));
            else
                load_addr = 12'($urandom);
            tick();
        end

        reset = 1'b0; load = 1'b0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/program_fetch.md
PROGRAM_FETCH -- requirements
Module: program_fetch

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 12, meaning program-counter and ROM address width.
REQ-002 The block SHALL have parameter DATA_W, default 8, meaning ROM word width, split into two DATA_W/2 fields.
REQ-003 The block SHALL have port clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 The block SHALL have port enable  input  1  run request; 1 permits new fetches.
REQ-006 The block SHALL have port load  input  1  jump request; 1 replaces PC with load_addr.
REQ-007 The block SHALL have port load_addr  input  ADDR_W  jump target.
REQ-008 The block SHALL have port rom_addr  output  ADDR_W  registered PC, drives the downstream 4kx8 ROM address.
REQ-009 The block SHALL have port rom_data  input  DATA_W  ROM read data, combinational from rom_addr in the same cycle.
REQ-010 The block SHALL have port instr  output  DATA_W/2  upper nibble of the fetched byte.
REQ-011 The block SHALL have port oprnd  output  DATA_W/2  lower nibble of the fetched byte.
REQ-012 The block SHALL have port fetch_valid  output  1  instr/oprnd hold a valid fetched byte.
REQ-013 The block SHALL have port fetch_ready  input  1  consumer accepts the byte this cycle.
REQ-014 The block SHALL have port pc_wrap  output  1  one-cycle pulse when PC advances from all-ones to zero.

Function
REQ-015 The FSM SHALL have three states: IDLE (no fetch), FETCH (rom_addr stable, capture rom_data), HOLD (fetch_valid=1, await handshake).
REQ-016 IDLE -> FETCH SHALL occur on the edge where enable=1 and load=0; otherwise the FSM stays in IDLE.
REQ-017 In FETCH, the next edge SHALL register rom_data: instr<=rom_data[7:4], oprnd<=rom_data[3:0], fetch_valid<=1, and the FSM SHALL move to HOLD; the fetch latency is one cycle from entering FETCH.
REQ-018 A handshake SHALL be fetch_valid=1 and fetch_ready=1 on the same edge.
REQ-019 On a handshake, PC SHALL increment by 1 modulo 2^ADDR_W; fetch_valid<=0; the next state SHALL be FETCH if enable=1, else IDLE.
REQ-020 In HOLD without a handshake, instr, oprnd, fetch_valid and rom_addr SHALL remain unchanged, regardless of enable.
REQ-021 load=1 SHALL take priority over handshake and increment in every state: PC<=load_addr, fetch_valid<=0, no increment, pc_wrap=0, next state FETCH if enable=1 else IDLE.
REQ-022 instr/oprnd SHALL retain their last value when fetch_valid=0.
REQ-023 On an increment from 2^ADDR_W-1, PC SHALL become 0 and pc_wrap SHALL be 1 for exactly the following cycle; pc_wrap SHALL be 0 at all other times, including on loads to 0.
REQ-024 Sustained throughput SHALL be one byte per two cycles with fetch_ready held at 1.
REQ-025 rom_addr SHALL change only on an increment, a load, or reset.

Reset
REQ-026 While reset=1 at an edge: PC/rom_addr=0, instr=0, oprnd=0, fetch_valid=0, pc_wrap=0, state=IDLE; reset SHALL override load, enable and handshake.
REQ-027 Reset SHALL abort any in-flight fetch; the held byte SHALL be discarded without a handshake.

Verification (ROM preloaded: 0x000=0xA5, 0x001=0x3C, 0xFFF=0x7E)
REQ-028 Reset for 2 cycles, enable=0 -> all outputs 0, rom_addr=0x000, no fetch_valid for 5 further cycles.
REQ-029 enable=1, fetch_ready=1 -> instr=0xA, oprnd=0x5 with fetch_valid 1 cycle after FETCH; then rom_addr=0x001, instr=0x3, oprnd=0xC two cycles later.
REQ-030 fetch_ready=0 for 3 cycles while in HOLD -> fetch_valid, instr=0xA, oprnd=0x5 and rom_addr=0x000 stable throughout; advance only on the first cycle with ready=1.
REQ-031 load=1, load_addr=0xFFF, enable=1, fetch_ready=1 -> instr=0x7, oprnd=0xE; then rom_addr=0x000 and pc_wrap high for exactly one cycle.
REQ-032 load=1, load_addr=0x001 on the same edge as a handshake at 0x000 -> fetch_valid drops, rom_addr=0x001 (not 0x002), next byte 0x3C.
REQ-033 reset=1 asserted during HOLD with fetch_ready=1 -> next edge: fetch_valid=0, rom_addr=0x000, instr=oprnd=0, state IDLE.
